// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants and the receiver FSM state encoding for uart_rx_fifo.
//   DATA_BITS : payload bits per frame
//   MIN_DIV   : smallest usable clocks-per-bit; smaller divisors are raised
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int MIN_DIV   = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_sync_fifo
// Registered first-word-fall-through FIFO. The head entry is always visible
// on head_data. A pop on an empty FIFO is ignored; a push on a full FIFO is
// accepted only when a pop happens in the same cycle.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (dropped when full without pop)
//   push_data  : entry to write
//   pop        : remove head entry (ignored when empty)
//   head_data  : current head entry
//   level      : occupancy, 0..DEPTH
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module uart_rx_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign level     = count;

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// UART receiver (8N1, programmable clocks-per-bit) with a small receive FIFO
// presented through a valid/ready interface, plus sticky error flags.
//
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit after
// the data bits and to add the parity_err_o output.
//
// Ports:
//   wb_clk_i     : system clock
//   wb_rst_i     : synchronous active-high reset
//   rx_i         : asynchronous serial input, idles high
//   clkdiv_i     : clocks per bit (values below 4 behave as 4)
//   rx_data_o    : FIFO head byte
//   rx_valid_o   : FIFO non-empty
//   rx_ready_i   : consumer accepts head (pop when valid && ready)
//   fifo_level_o : FIFO occupancy
//   busy_o       : frame in progress
//   frame_err_o  : sticky, stop bit sampled low
//   overrun_o    : sticky, good byte arrived while FIFO full
//   parity_err_o : sticky, parity mismatch (parity build only)
//   err_clr_i    : clears sticky flags (a same-cycle new error wins)
//
// state  | meaning
// IDLE   | line idle, waiting for rxs low
// START  | timing to mid start bit, rejects glitches
// DATA   | sampling data bits LSB first
// PARITY | sampling even-parity bit (parity build only)
// STOP   | sampling stop bit, push byte if good
// BREAK  | line held low after a bad stop, wait for release
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          rx_i,
    input  logic [DIV_W-1:0]              clkdiv_i,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          busy_o,
    output logic                          frame_err_o,
    output logic                          overrun_o,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err_o,
`endif
    input  logic                          err_clr_i
);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = PARITY;
`endif
    localparam logic [2:0] ST_STOP   = STOP;
    localparam logic [2:0] ST_BREAK  = BREAK;

    localparam int IDX_W = $clog2(DATA_BITS);

    logic                  rx_meta;
    logic                  rxs;
    logic [2:0]            state;
    logic [DIV_W-1:0]      div_eff;
    logic [DIV_W-1:0]      div_q;
    logic [DIV_W-1:0]      cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_BITS-1:0]  shreg;
    logic                  tick;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  frame_err_set;
    logic                  overrun_set;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
        end
    end

    assign div_eff = (clkdiv_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clkdiv_i;
    assign tick    = (cnt == '0);

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic parity_set;
    assign parity_set = (state == ST_PARITY) && tick && ((^shreg) != rxs);
    assign push       = (state == ST_STOP) && tick && rxs && !par_bad;
`else
    assign push       = (state == ST_STOP) && tick && rxs;
`endif
    assign frame_err_set = (state == ST_STOP) && tick && !rxs;
    // When full, a pop frees a slot this cycle, so only push-without-pop overruns.
    assign overrun_set   = push && fifo_full && !rx_ready_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            div_q   <= DIV_W'(MIN_DIV);
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            if (state != ST_IDLE && !tick) begin
                cnt <= cnt - 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        // Half a bit to land in the middle of the start bit.
                        div_q <= div_eff;
                        cnt   <= (div_eff >> 1) - DIV_W'(1);
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (rxs) begin
                            state <= ST_IDLE;
                        end else begin
                            bit_idx <= '0;
                            cnt     <= div_q - DIV_W'(1);
                            state   <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg[bit_idx] <= rxs;
                        cnt            <= div_q - DIV_W'(1);
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        par_bad <= ((^shreg) != rxs);
                        cnt     <= div_q - DIV_W'(1);
                        state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        state <= rxs ? ST_IDLE : ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (rxs) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (frame_err_set) begin
                frame_err_o <= 1'b1;
            end else if (err_clr_i) begin
                frame_err_o <= 1'b0;
            end
            if (overrun_set) begin
                overrun_o <= 1'b1;
            end else if (err_clr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            parity_err_o <= 1'b0;
        end else if (parity_set) begin
            parity_err_o <= 1'b1;
        end else if (err_clr_i) begin
            parity_err_o <= 1'b0;
        end
    end
`endif

    uart_rx_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (push),
        .push_data (shreg),
        .pop       (rx_ready_i),
        .head_data (rx_data_o),
        .level     (fifo_level_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_valid_o = !fifo_empty;
    assign busy_o     = (state != ST_IDLE);

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- User-project-side UART receiver: the far end of the testbench transmitter that drives mprj_io[5] (tx_start/tx_data/tx_busy).
- Deserialises 8N1 frames at a programmable clocks-per-bit rate.
- Buffers received bytes in a small FIFO and presents them to the Wishbone/firmware side through a valid/ready interface.
- Reports sticky frame-error and overrun flags.

Parameters:
- DIV_W, 16, width of the clocks-per-bit divisor.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, minimum 2.

Ports:
- wb_clk_i  in  1  system clock (40 MHz in simulation).
- wb_rst_i  in  1  synchronous, active-high reset.
- rx_i  in  1  serial input from the pad, asynchronous, idles high.
- clkdiv_i  in  DIV_W  clocks per bit; values below 4 are treated as 4.
- rx_data_o  out  8  FIFO head byte.
- rx_valid_o  out  1  FIFO non-empty.
- rx_ready_i  in  1  consumer accepts the head; a pop happens when rx_valid_o and rx_ready_i are both high.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- busy_o  out  1  frame in progress (state is not IDLE).
- frame_err_o  out  1  sticky: stop bit sampled low.
- overrun_o  out  1  sticky: a good byte arrived while the FIFO was full.
- err_clr_i  in  1  clears both sticky flags.

Behaviour:
- Reset (wb_rst_i=1 at a clock edge):
  - state IDLE; FIFO empty.
  - rx_valid_o=0, rx_data_o=0, fifo_level_o=0, busy_o=0, frame_err_o=0, overrun_o=0.
  - Both synchroniser flops set to 1.
  - Reset mid-frame abandons the frame; no partial byte is pushed.
- Input path: rx_i passes through 2 flops; all logic uses the synchronised signal rxs. This adds 2 cycles of input latency.
- Divisor: div = max(clkdiv_i, 4), latched at start detection. Changing clkdiv_i mid-frame has no effect on the current frame.
- Bit counter: down-counter cnt. A "tick" occurs when cnt==0; on each tick cnt reloads with div-1.
- IDLE:
  - rxs==0 -> cnt = (div>>1)-1, go to START.
- START, on tick:
  - rxs==1 -> false start; return to IDLE with no output and no error.
  - rxs==0 -> bit index = 0, go to DATA.
- DATA, on each tick:
  - shift rxs into bit[index], LSB first.
  - after index 7 -> go to STOP.
- STOP, on tick:
  - rxs==1 -> push the byte; go to IDLE.
  - rxs==0 -> set frame_err_o, discard the byte, go to BREAK.
- BREAK: stay until rxs==1, then go to IDLE. A held-low line therefore yields exactly one error, not repeated frames.
- Latency: rx_valid_o rises 1 cycle after the stop-bit tick when the FIFO was empty. rx_data_o is valid in that same cycle.
- FIFO behaviour:
  - Registered, first-word-fall-through.
  - rx_data_o always shows the head entry.
  - Full with push and no pop -> byte dropped, overrun_o set, contents unchanged.
  - Full with simultaneous push and pop -> both occur; level stays FIFO_DEPTH; no overrun.
  - Empty with pop requested -> ignored (rx_valid_o=0).
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: err_clr_i clears both flags. If a new error event occurs in the same cycle, the flag ends set (set wins).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - an even-parity bit follows the 8 data bits; a PARITY state sits between DATA and STOP.
  - new output parity_err_o (1 bit, sticky, reset 0, cleared by err_clr_i with set-wins).
  - on parity mismatch the byte is discarded, STOP is still checked, and the FSM proceeds normally.
- When undefined: the port and state do not exist; frame is 8N1.

Decomposition:
- Package uart_pkg:
  - FSM state enum {IDLE, START, DATA, PARITY, STOP, BREAK}.
  - constants DATA_BITS=8, MIN_DIV=4.
- One sub-module: uart_rx_sync_fifo (generic FIFO with depth parameter, push/pop/level/full/empty).
- Synchroniser and FSM stay in uart_rx_fifo.

Test Plan:
- Basic byte: clkdiv_i=16, serial 0x3D, rx_ready_i=0 -> rx_valid_o=1, rx_data_o=0x3D, fifo_level_o=1; frame_err_o=0.
- Back-to-back: send 0x3D then 0x0A with no idle gap, then pop twice -> reads return 0x3D, 0x0A; rx_valid_o=0 afterwards.
- Overrun: FIFO_DEPTH=4, send 0x01..0x05 with rx_ready_i=0 -> level=4, overrun_o=1; pops return 0x01..0x04.
- Overrun corner: full FIFO, rx_ready_i=1 exactly on the 5th push cycle -> no overrun.
- Frame error: send 0x55 with stop bit low, hold rx_i low 40 cycles, then high -> frame_err_o=1, no push, single error. err_clr_i pulse -> 0.
- Glitch and reset: 3-cycle low pulse on rx_i at clkdiv_i=16 -> no byte, no error. Assert wb_rst_i during bit 4 of 0xA5 -> all outputs 0. A following 0xA5 frame is received correctly.
